// File: rtl/text_ram_arbiter.sv
// Single-port character-RAM arbiter: display reads always win, then the clear
// sweep, then queued keyboard writes drained from a small FIFO.
module text_ram_arbiter #(
  parameter int ADDR_W     = 6,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rd_req,
  input  logic [ADDR_W-1:0]             rd_addr,
  output logic [DATA_W-1:0]             rd_data,
  output logic                          rd_valid,
  input  logic                          wr_req,
  input  logic [ADDR_W-1:0]             wr_addr,
  input  logic [DATA_W-1:0]             wr_data,
  output logic                          wr_ready,
  input  logic                          clr_req,
  output logic                          clr_busy,
  output logic                          clr_done,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          ram_en,
  output logic                          ram_we,
  output logic [ADDR_W-1:0]             ram_addr,
  output logic [DATA_W-1:0]             ram_wdata,
  input  logic [DATA_W-1:0]             ram_rdata
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   clr_cnt_reg, clr_cnt_next;
  logic [PTR_W-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [LVL_W-1:0]    level_reg;
  logic                rd_p1_reg, rd_p2_reg;

  logic [ADDR_W-1:0]   fifo_addr_mem [FIFO_DEPTH];
  logic [DATA_W-1:0]   fifo_data_mem [FIFO_DEPTH];

  logic fifo_full, fifo_empty, push, grant_rd, grant_clr, grant_pop, clr_last;
  logic [ADDR_W-1:0]   head_addr;
  logic [DATA_W-1:0]   head_data;

  assign fifo_full  = (level_reg == LVL_W'(FIFO_DEPTH));
  assign fifo_empty = (level_reg == '0);
  assign push       = wr_req && !fifo_full;
  assign head_addr  = fifo_addr_mem[rd_ptr_reg];
  assign head_data  = fifo_data_mem[rd_ptr_reg];

  // One RAM operation per cycle; reads are never held off.
  assign grant_rd   = rd_req;
  assign grant_clr  = !rd_req && (state_reg == CLEAR);
  assign grant_pop  = !rd_req && (state_reg == IDLE) && !fifo_empty;
  assign clr_last   = grant_clr && (clr_cnt_reg == {ADDR_W{1'b1}});

  assign wr_ready   = !fifo_full;
  assign fifo_level = level_reg;
  assign clr_busy   = (state_reg == CLEAR);

  always_comb begin
    state_next   = state_reg;
    clr_cnt_next = clr_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (clr_req) begin
          state_next   = CLEAR;
          clr_cnt_next = '0;
        end
      end
      CLEAR: begin
        if (clr_last) begin
          state_next   = IDLE;
          clr_cnt_next = '0;
        end else if (grant_clr) begin
          clr_cnt_next = clr_cnt_reg + ADDR_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // FIFO storage carries no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_mem[wr_ptr_reg] <= wr_addr;
      fifo_data_mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      clr_cnt_reg <= '0;
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      level_reg   <= '0;
      overflow    <= 1'b0;
      ram_en      <= 1'b0;
      ram_we      <= 1'b0;
      ram_addr    <= '0;
      ram_wdata   <= '0;
      rd_p1_reg   <= 1'b0;
      rd_p2_reg   <= 1'b0;
      rd_valid    <= 1'b0;
      rd_data     <= '0;
      clr_done    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      clr_cnt_reg <= clr_cnt_next;

      if (push)
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (grant_pop)
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push, grant_pop})
        2'b10:   level_reg <= level_reg + LVL_W'(1);
        2'b01:   level_reg <= level_reg - LVL_W'(1);
        default: level_reg <= level_reg;
      endcase

      // A push against a full FIFO is lost even if a pop frees a slot this cycle.
      if (wr_req && fifo_full)
        overflow <= 1'b1;

      ram_en <= grant_rd || grant_clr || grant_pop;
      ram_we <= grant_clr || grant_pop;
      if (grant_rd) begin
        ram_addr <= rd_addr;
      end else if (grant_clr) begin
        ram_addr  <= clr_cnt_reg;
        ram_wdata <= '0;
      end else if (grant_pop) begin
        ram_addr  <= head_addr;
        ram_wdata <= head_data;
      end

      // Request -> RAM port -> RAM output register -> rd_data.
      rd_p1_reg <= grant_rd;
      rd_p2_reg <= rd_p1_reg;
      rd_valid  <= rd_p2_reg;
      if (rd_p2_reg)
        rd_data <= ram_rdata;

      clr_done <= clr_last;
    end
  end

endmodule

// File: tb/tb_text_ram_arbiter.sv
// Directed bench for text_ram_arbiter with a transaction-level model of the
// RAM contents, write queue, clear sweep and read latency.
module tb_text_ram_arbiter;

  logic       clk, reset;
  logic       rd_req, wr_req, clr_req;
  logic [5:0] rd_addr, wr_addr;
  logic [7:0] wr_data, rd_data, ram_wdata, ram_rdata;
  logic       rd_valid, wr_ready, clr_busy, clr_done, overflow, ram_en, ram_we;
  logic [2:0] fifo_level;
  logic [5:0] ram_addr;

  text_ram_arbiter #(.ADDR_W(6), .DATA_W(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done),
    .overflow(overflow), .fifo_level(fifo_level),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External RAM, one-cycle read latency, preloaded with data = address.
  logic [7:0] bench_mem [64];
  initial begin
    for (int a = 0; a < 64; a++) bench_mem[a] <= 8'(a);
    ram_rdata <= 8'h00;
    forever begin
      @(posedge clk);
      if (ram_en) begin
        if (ram_we) bench_mem[ram_addr] <= ram_wdata;
        else        ram_rdata <= bench_mem[ram_addr];
      end
    end
  end

  typedef struct { logic [5:0] a; logic [7:0] d; } ent_t;
  typedef struct { int due; logic [7:0] d; } rd_t;

  int vectors = 0;
  int miscompares = 0;

  // Model state
  ent_t       q[$];
  rd_t        pend[$];
  logic [7:0] shadow [64];
  bit         m_clearing, m_ovf;
  int         m_clr_addr;
  logic [5:0] e_addr;
  logic [7:0] e_wdata;
  int         cyc;

  // Per-phase observation counters
  int n_valid, n_we, n_done, n_busy;
  logic [7:0] last_rd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_counts();
    n_valid = 0; n_we = 0; n_done = 0; n_busy = 0;
  endtask

  task automatic model_reset();
    q.delete();
    pend.delete();
    m_clearing = 1'b0;
    m_ovf      = 1'b0;
    m_clr_addr = 0;
    e_addr     = 6'h00;
    e_wdata    = 8'h00;
  endtask

  // Advance one clock: apply the model to the inputs that were held across the
  // edge, then compare every DUT output against it.
  task automatic step();
    bit         e_en, e_we, e_done, e_valid, full0, clr0;
    logic [7:0] e_rdata;
    ent_t       ent;
    rd_t        r;
    @(posedge clk);
    #1;
    cyc++;
    e_en = 0; e_we = 0; e_done = 0; e_valid = 0; e_rdata = 8'h00;
    full0 = (q.size() == 4);
    clr0  = m_clearing;
    if (rd_req) begin
      e_en = 1; e_addr = rd_addr;
      r.due = cyc + 2; r.d = shadow[rd_addr];
      pend.push_back(r);
    end else if (clr0) begin
      e_en = 1; e_we = 1; e_addr = 6'(m_clr_addr); e_wdata = 8'h00;
      shadow[m_clr_addr] = 8'h00;
      if (m_clr_addr == 63) begin
        m_clearing = 1'b0; e_done = 1;
      end else begin
        m_clr_addr++;
      end
    end else if (q.size() > 0) begin
      ent = q.pop_front();
      e_en = 1; e_we = 1; e_addr = ent.a; e_wdata = ent.d;
      shadow[ent.a] = ent.d;
    end
    if (!clr0 && clr_req) begin
      m_clearing = 1'b1; m_clr_addr = 0;
    end
    if (wr_req) begin
      if (full0) m_ovf = 1'b1;
      else begin ent.a = wr_addr; ent.d = wr_data; q.push_back(ent); end
    end
    if (pend.size() > 0 && pend[0].due == cyc) begin
      r = pend.pop_front();
      e_valid = 1; e_rdata = r.d;
    end

    chk("ram_en", 32'(ram_en), 32'(e_en));
    chk("ram_we", 32'(ram_we), 32'(e_we));
    chk("ram_addr", 32'(ram_addr), 32'(e_addr));
    chk("ram_wdata", 32'(ram_wdata), 32'(e_wdata));
    chk("rd_valid", 32'(rd_valid), 32'(e_valid));
    if (e_valid) chk("rd_data", 32'(rd_data), 32'(e_rdata));
    chk("fifo_level", 32'(fifo_level), 32'(q.size()));
    chk("wr_ready", 32'(wr_ready), 32'(q.size() < 4));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("clr_busy", 32'(clr_busy), 32'(m_clearing));
    chk("clr_done", 32'(clr_done), 32'(e_done));

    if (rd_valid) begin n_valid++; last_rd = rd_data; end
    if (ram_en && ram_we) n_we++;
    if (clr_done) n_done++;
    if (clr_busy) n_busy++;
  endtask

  task automatic idle(input int n);
    rd_req = 0; wr_req = 0; clr_req = 0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic read_one(input logic [5:0] a);
    rd_req = 1; rd_addr = a; step();
    rd_req = 0; step(); step(); step();
  endtask

  initial begin
    int t;
    rd_req = 0; wr_req = 0; clr_req = 0;
    rd_addr = 0; wr_addr = 0; wr_data = 0;
    cyc = 0; last_rd = 8'h00;
    for (int a = 0; a < 64; a++) shadow[a] = 8'(a);
    model_reset();
    clear_counts();

    // Reset state
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ram_en", 32'(ram_en), 32'd0);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_wr_ready", 32'(wr_ready), 32'd1);
    chk("rst_fifo_level", 32'(fifo_level), 32'd0);
    chk("rst_clr_busy", 32'(clr_busy), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    idle(2);
    $display("phase reset: done");

    // 64 back-to-back reads of preloaded data
    clear_counts();
    for (int i = 0; i < 64; i++) begin
      rd_req = 1; rd_addr = 6'(i); step();
    end
    idle(3);
    chk("burst_read_count", 32'(n_valid), 32'd64);
    chk("burst_read_last", 32'(last_rd), 32'd63);
    $display("phase read burst: %0d reads returned", n_valid);

    // Single queued write with the display idle
    wr_req = 1; wr_addr = 6'd5; wr_data = 8'h41; step();
    chk("push_level", 32'(fifo_level), 32'd1);
    wr_req = 0; step();
    chk("pop_we", 32'(ram_we), 32'd1);
    chk("pop_addr", 32'(ram_addr), 32'd5);
    chk("pop_wdata", 32'(ram_wdata), 32'h41);
    chk("pop_level", 32'(fifo_level), 32'd0);
    idle(1);
    read_one(6'd5);
    chk("readback_5", 32'(last_rd), 32'h41);
    $display("phase single write: addr 5 <- 0x41");

    // Five pushes while reads hold the RAM
    rd_req = 1;
    for (int i = 0; i < 5; i++) begin
      rd_addr = 6'(30 + i); wr_req = 1;
      wr_addr = 6'(10 + i); wr_data = 8'(8'hA0 + i);
      step();
      if (i == 3) begin
        chk("full_level", 32'(fifo_level), 32'd4);
        chk("full_wr_ready", 32'(wr_ready), 32'd0);
      end
    end
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_level", 32'(fifo_level), 32'd4);
    rd_req = 0; wr_addr = 6'd15; wr_data = 8'hB5; step();
    chk("drop_with_pop_level", 32'(fifo_level), 32'd3);
    wr_addr = 6'd16; wr_data = 8'hB6; step();
    chk("push_pop_level", 32'(fifo_level), 32'd3);
    idle(5);
    for (int i = 10; i < 17; i++) begin
      rd_req = 1; rd_addr = 6'(i); step();
    end
    idle(3);
    read_one(6'd15);
    chk("dropped_not_written", 32'(last_rd), 32'd15);
    read_one(6'd13);
    chk("fifo_order_13", 32'(last_rd), 32'hA3);
    $display("phase fifo overflow: level 4, 5th push dropped");

    // Clear with no competing reads
    clear_counts();
    clr_req = 1; step(); clr_req = 0;
    t = 0;
    while (n_done == 0 && t < 200) begin step(); t++; end
    idle(3);
    chk("clr_write_count", 32'(n_we), 32'd64);
    chk("clr_done_count", 32'(n_done), 32'd1);
    chk("clr_busy_cycles", 32'(n_busy), 32'd64);
    read_one(6'd41);
    chk("cleared_41", 32'(last_rd), 32'd0);
    $display("phase clear: %0d writes, %0d done pulses", n_we, n_done);

    // Clear with reads every other cycle
    clear_counts();
    clr_req = 1; step(); clr_req = 0;
    t = 0;
    while (n_done == 0 && t < 300) begin
      rd_req = (t % 2 == 0); rd_addr = 6'(t / 2); step(); t++;
    end
    idle(3);
    chk("clr_rd_busy_cycles", 32'(n_busy), 32'd128);
    chk("clr_rd_done_count", 32'(n_done), 32'd1);
    chk("clr_rd_reads", 32'(n_valid), 32'd64);
    $display("phase clear with reads: busy %0d cycles, %0d reads", n_busy, n_valid);

    // Push during a clear survives it
    clear_counts();
    clr_req = 1; step(); clr_req = 0;
    t = 0;
    while (n_done == 0 && t < 200) begin
      wr_req = (t == 5); wr_addr = 6'd7; wr_data = 8'h77;
      step();
      if (n_done != 0) chk("deferred_level_at_done", 32'(fifo_level), 32'd1);
      t++;
    end
    wr_req = 0;
    idle(2);
    chk("deferred_drained", 32'(fifo_level), 32'd0);
    read_one(6'd7);
    chk("survives_clear_7", 32'(last_rd), 32'h77);
    $display("phase push during clear: addr 7 <- 0x77 kept");

    // Reset in the middle of a sweep
    clear_counts();
    clr_req = 1; step(); clr_req = 0;
    t = 0;
    while (m_clr_addr != 20 && t < 100) begin step(); t++; end
    chk("abort_point", 32'(m_clr_addr), 32'd20);
    chk("ovf_before_reset", 32'(overflow), 32'd1);
    #4;
    reset = 1'b0;
    #1;
    chk("abort_busy", 32'(clr_busy), 32'd0);
    chk("abort_done", 32'(clr_done), 32'd0);
    chk("abort_ram_en", 32'(ram_en), 32'd0);
    chk("abort_ovf", 32'(overflow), 32'd0);
    chk("abort_wr_ready", 32'(wr_ready), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    idle(3);
    chk("abort_no_done", 32'(n_done), 32'd0);
    clr_req = 1; step(); clr_req = 0;
    step();
    chk("restart_addr", 32'(ram_addr), 32'd0);
    chk("restart_we", 32'(ram_we), 32'd1);
    t = 0;
    while (n_done == 0 && t < 200) begin step(); t++; end
    idle(2);
    chk("restart_done", 32'(n_done), 32'd1);
    $display("phase reset during clear: sweep restarted from 0");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
